// File: rtl/core_pipe_id_if.sv
// Handshake and data bundle between fetch, the ID stage and IE.
// The slave modport is the ID stage; the master modport is its surroundings.
interface core_pipe_id_if #(
  parameter int XLEN = 32
);
  logic            if_validout;
  logic [XLEN-1:0] if_ram_pc;
  logic            ram_done;
  logic [31:0]     ram_rdata;
  logic            id_allowin;

  logic            ie_allowin;
  logic            ie_result_jmp;
  logic            ie_valid;
  logic            ie_mem_load;
  logic [4:0]      ie_rd;

  logic            id_validout;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_inst;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [31:0]     id_imm;
  logic [3:0]      id_alu_op;
  logic            id_mem_load;
  logic            id_mem_store;
  logic            id_branch;
  logic            id_jal;
  logic            id_jalr;
  logic            id_wb_en;
  logic            id_illegal;

  modport master (
    output if_validout, if_ram_pc, ram_done, ram_rdata,
    output ie_allowin, ie_result_jmp, ie_valid, ie_mem_load, ie_rd,
    input  id_allowin, id_validout, id_pc, id_inst, id_rs1, id_rs2, id_rd,
    input  id_imm, id_alu_op, id_mem_load, id_mem_store, id_branch,
    input  id_jal, id_jalr, id_wb_en, id_illegal
  );

  modport slave (
    input  if_validout, if_ram_pc, ram_done, ram_rdata,
    input  ie_allowin, ie_result_jmp, ie_valid, ie_mem_load, ie_rd,
    output id_allowin, id_validout, id_pc, id_inst, id_rs1, id_rs2, id_rd,
    output id_imm, id_alu_op, id_mem_load, id_mem_store, id_branch,
    output id_jal, id_jalr, id_wb_en, id_illegal
  );
endinterface

// File: rtl/core_pipe_id.sv
// RV32I instruction-decode pipeline stage: single-entry holding register,
// combinational decode, load-use stall against IE and flush on IE jumps.
module core_pipe_id #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  core_pipe_id_if.slave bus
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  logic            v;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;

  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [31:0] imm;
  logic        rs1_use, rs2_use, rd_use, f7_use, wb_use;
  logic        mem_load, mem_store, branch, jal, jalr, illegal;
  logic [4:0]  rs1, rs2, rd;
  logic        stall, accept, handoff;

  assign i_imm = {{20{inst_q[31]}}, inst_q[31:20]};
  assign s_imm = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
  assign b_imm = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign u_imm = {inst_q[31:12], 12'b0};
  assign j_imm = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

  always_comb begin
    rs1_use   = 1'b0;
    rs2_use   = 1'b0;
    rd_use    = 1'b0;
    f7_use    = 1'b0;
    wb_use    = 1'b0;
    mem_load  = 1'b0;
    mem_store = 1'b0;
    branch    = 1'b0;
    jal       = 1'b0;
    jalr      = 1'b0;
    illegal   = 1'b0;
    imm       = 32'h0;
    case (inst_q[6:0])
      OP_R: begin
        rs1_use = 1'b1; rs2_use = 1'b1; rd_use = 1'b1; wb_use = 1'b1; f7_use = 1'b1;
      end
      OP_IMM: begin
        rs1_use = 1'b1; rd_use = 1'b1; wb_use = 1'b1; imm = i_imm;
        // Only the shift-immediates carry a meaningful funct7[5] (SRAI vs SRLI)
        f7_use  = (inst_q[14:12] == 3'b001) || (inst_q[14:12] == 3'b101);
      end
      OP_LOAD: begin
        rs1_use = 1'b1; rd_use = 1'b1; wb_use = 1'b1; mem_load = 1'b1; imm = i_imm;
      end
      OP_STORE: begin
        rs1_use = 1'b1; rs2_use = 1'b1; mem_store = 1'b1; imm = s_imm;
      end
      OP_BRANCH: begin
        rs1_use = 1'b1; rs2_use = 1'b1; branch = 1'b1; imm = b_imm;
      end
      OP_JAL: begin
        rd_use = 1'b1; wb_use = 1'b1; jal = 1'b1; imm = j_imm;
      end
      OP_JALR: begin
        rs1_use = 1'b1; rd_use = 1'b1; wb_use = 1'b1; jalr = 1'b1; imm = i_imm;
      end
      OP_LUI, OP_AUIPC: begin
        rd_use = 1'b1; wb_use = 1'b1; imm = u_imm;
      end
      OP_FENCE, OP_SYSTEM: begin
        illegal = 1'b0;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign rs1 = rs1_use ? inst_q[19:15] : 5'd0;
  assign rs2 = rs2_use ? inst_q[24:20] : 5'd0;
  assign rd  = rd_use  ? inst_q[11:7]  : 5'd0;

  // Operand fields are already zeroed when unused, so a zero match is excluded via ie_rd
  assign stall = v && bus.ie_valid && bus.ie_mem_load && (bus.ie_rd != 5'd0) &&
                 ((rs1_use && (rs1 == bus.ie_rd)) || (rs2_use && (rs2 == bus.ie_rd)));

  assign bus.id_validout = v && !stall;
  assign bus.id_allowin  = !v || (bus.ie_allowin && !stall);

  assign accept  = bus.if_validout && bus.ram_done && bus.id_allowin && !bus.ie_result_jmp;
  assign handoff = bus.id_validout && bus.ie_allowin;

  always_ff @(posedge clk) begin
    if (rst) begin
      v      <= 1'b0;
      pc_q   <= '0;
      inst_q <= 32'h0000_0013;
    end else if (bus.ie_result_jmp) begin
      v <= 1'b0;
    end else if (accept) begin
      v      <= 1'b1;
      pc_q   <= bus.if_ram_pc;
      inst_q <= bus.ram_rdata;
    end else if (handoff) begin
      v <= 1'b0;
    end
  end

  assign bus.id_pc        = pc_q;
  assign bus.id_inst      = inst_q;
  assign bus.id_rs1       = rs1;
  assign bus.id_rs2       = rs2;
  assign bus.id_rd        = rd;
  assign bus.id_imm       = imm;
  assign bus.id_alu_op    = {f7_use ? inst_q[30] : 1'b0, inst_q[14:12]};
  assign bus.id_mem_load  = mem_load;
  assign bus.id_mem_store = mem_store;
  assign bus.id_branch    = branch;
  assign bus.id_jal       = jal;
  assign bus.id_jalr      = jalr;
  assign bus.id_wb_en     = wb_use && (inst_q[11:7] != 5'd0);
  assign bus.id_illegal   = illegal;

endmodule

// File: tb/tb_core_pipe_id.sv
// Self-checking bench for core_pipe_id: directed scenarios plus randomized
// traffic compared against a slot-level reference model of the stage.
module tb_core_pipe_id;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  core_pipe_id_if #(.XLEN(32)) bus ();

  core_pipe_id #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the contents of the one-entry slot
  logic        mv;
  logic [31:0] mpc;
  logic [31:0] minst;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [6:0]  flags;
    logic        r1u;
    logic        r2u;
  } dec_t;

  // flags = {load, store, branch, jal, jalr, wb_en, illegal}
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t        d;
    logic [31:0] sgn;
    logic        rdu;
    logic        f7;
    int          kind;
    logic [4:0]  base;
    sgn  = {32{w[31]}};
    rdu  = 1'b0;
    f7   = 1'b0;
    kind = 0;
    base = 5'b0;
    d    = '0;
    case (w[6:0])
      7'b0110011: begin d.r1u = 1; d.r2u = 1; rdu = 1; f7 = 1; end
      7'b0010011: begin d.r1u = 1; rdu = 1; kind = 1; f7 = (w[14:12] == 3'd1) || (w[14:12] == 3'd5); end
      7'b0000011: begin d.r1u = 1; rdu = 1; kind = 1; base = 5'b10000; end
      7'b0100011: begin d.r1u = 1; d.r2u = 1; kind = 2; base = 5'b01000; end
      7'b1100011: begin d.r1u = 1; d.r2u = 1; kind = 3; base = 5'b00100; end
      7'b1101111: begin rdu = 1; kind = 5; base = 5'b00010; end
      7'b1100111: begin d.r1u = 1; rdu = 1; kind = 1; base = 5'b00001; end
      7'b0110111, 7'b0010111: begin rdu = 1; kind = 4; end
      7'b0001111, 7'b1110011: begin kind = 0; end
      default: begin kind = -1; end
    endcase
    case (kind)
      1: d.imm = (sgn << 12) | {20'b0, w[31:20]};
      2: d.imm = (sgn << 12) | {20'b0, w[31:25], w[11:7]};
      3: d.imm = (sgn << 12) | {20'b0, w[7], w[30:25], w[11:8], 1'b0};
      4: d.imm = w & 32'hFFFF_F000;
      5: d.imm = (sgn << 20) | {12'b0, w[19:12], w[20], w[30:21], 1'b0};
      default: d.imm = 32'h0;
    endcase
    d.rs1   = d.r1u ? w[19:15] : 5'd0;
    d.rs2   = d.r2u ? w[24:20] : 5'd0;
    d.rd    = rdu ? w[11:7] : 5'd0;
    d.alu   = {f7 & w[30], w[14:12]};
    d.flags = {base, rdu && (w[11:7] != 5'd0), kind == -1};
    return d;
  endfunction

  function automatic logic exp_stall();
    dec_t d;
    d = ref_decode(minst);
    if (!(mv && bus.ie_valid && bus.ie_mem_load) || bus.ie_rd == 5'd0) return 1'b0;
    return (d.r1u && d.rs1 == bus.ie_rd) || (d.r2u && d.rs2 == bus.ie_rd);
  endfunction

  function automatic logic exp_allowin();
    return !mv || (bus.ie_allowin && !exp_stall());
  endfunction

  function automatic logic [123:0] exp_vec();
    dec_t d;
    d = ref_decode(minst);
    return {mv && !exp_stall(), exp_allowin(), mpc, minst,
            d.rs1, d.rs2, d.rd, d.imm, d.alu, d.flags};
  endfunction

  function automatic logic [123:0] dut_vec();
    return {bus.id_validout, bus.id_allowin, bus.id_pc, bus.id_inst,
            bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_imm, bus.id_alu_op,
            bus.id_mem_load, bus.id_mem_store, bus.id_branch, bus.id_jal,
            bus.id_jalr, bus.id_wb_en, bus.id_illegal};
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge
  task automatic tick();
    logic        nv;
    logic [31:0] npc, ninst;
    logic        acc;
    acc   = bus.if_validout && bus.ram_done && exp_allowin() && !bus.ie_result_jmp;
    nv    = mv;
    npc   = mpc;
    ninst = minst;
    if (rst) begin
      nv = 1'b0; npc = 32'h0; ninst = 32'h13;
    end else if (bus.ie_result_jmp) begin
      nv = 1'b0;
    end else if (acc) begin
      nv = 1'b1; npc = bus.if_ram_pc; ninst = bus.ram_rdata;
    end else if (mv && !exp_stall() && bus.ie_allowin) begin
      nv = 1'b0;
    end
    @(posedge clk);
    #1;
    mv    = nv;
    mpc   = npc;
    minst = ninst;
  endtask

  task automatic applyStimulus(input logic ifv, input logic done, input logic [31:0] pc,
                               input logic [31:0] word, input logic ie_ok);
    bus.if_validout   = ifv;
    bus.ram_done      = done;
    bus.if_ram_pc     = pc;
    bus.ram_rdata     = word;
    bus.ie_allowin    = ie_ok;
    bus.ie_result_jmp = 1'b0;
    bus.ie_valid      = 1'b0;
    bus.ie_mem_load   = 1'b0;
    bus.ie_rd         = 5'd0;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.id_validout, bus.id_allowin, bus.id_illegal, bus.id_pc, bus.id_inst} !==
        {1'b1 ^ 1'b1, 1'b1, 1'b0, 32'h0, 32'h13}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got v=%b a=%b ill=%b pc=%h inst=%h, want 0 1 0 0 00000013",
               bus.id_validout, bus.id_allowin, bus.id_illegal, bus.id_pc, bus.id_inst);
    end
    vectors++;
    if ({bus.id_mem_load, bus.id_mem_store, bus.id_branch, bus.id_jal, bus.id_jalr} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b want 00000",
               {bus.id_mem_load, bus.id_mem_store, bus.id_branch, bus.id_jal, bus.id_jalr});
    end
  endtask

  task automatic test_addi();
    applyStimulus(1'b1, 1'b1, 32'h0, 32'h0050_0093, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    vectors++;
    if ({bus.id_validout, bus.id_rd, bus.id_rs1, bus.id_imm, bus.id_wb_en, bus.id_alu_op} !==
        {1'b1, 5'd1, 5'd0, 32'd5, 1'b1, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL addi_decode: got v=%b rd=%0d rs1=%0d imm=%h wb=%b alu=%h, want 1 1 0 00000005 1 0",
               bus.id_validout, bus.id_rd, bus.id_rs1, bus.id_imm, bus.id_wb_en, bus.id_alu_op);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 1'b1, 32'h0, 32'h13, 1'b1);
    tick();
    for (int i = 1; i <= 3; i++) begin
      if (i < 3) applyStimulus(1'b1, 1'b1, 32'(4 * i), 32'h13, 1'b1);
      else       applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      #1;
      vectors++;
      if ({bus.id_validout, bus.id_pc, bus.id_allowin} !== {1'b1, 32'(4 * (i - 1)), 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL back_to_back_%0d: got v=%b pc=%h a=%b, want 1 %h 1",
                 i, bus.id_validout, bus.id_pc, bus.id_allowin, 32'(4 * (i - 1)));
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h0010_8133, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h24, 32'h13, 1'b1);
    bus.ie_valid    = 1'b1;
    bus.ie_mem_load = 1'b1;
    bus.ie_rd       = 5'd1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if ({bus.id_validout, bus.id_allowin, bus.id_pc} !== {1'b0, 1'b0, 32'h20}) begin
        miscompares++;
        $display("[TB] FAIL load_use_stall_%0d: got v=%b a=%b pc=%h, want 0 0 00000020",
                 i, bus.id_validout, bus.id_allowin, bus.id_pc);
      end
      tick();
    end
    bus.ie_rd = 5'd3;
    #1;
    vectors++;
    if (bus.id_validout !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL load_use_other_rd: got v=%b want 1", bus.id_validout);
    end
    bus.ie_rd    = 5'd1;
    bus.ie_valid = 1'b0;
    #1;
    vectors++;
    if ({bus.id_validout, bus.id_allowin} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL load_use_release: got v=%b a=%b want 1 1", bus.id_validout, bus.id_allowin);
    end
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, 1'b1, 32'h100, 32'h0050_0093, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h104, 32'h00A0_0513, 1'b1);
    bus.ie_result_jmp = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({bus.id_validout, bus.id_allowin} !== 2'b01) begin
        miscompares++;
        $display("[TB] FAIL flush_%0d: got v=%b a=%b pc=%h, want 0 1",
                 i, bus.id_validout, bus.id_allowin, bus.id_pc);
      end
      tick();
    end
  endtask

  task automatic test_decode_edges();
    applyStimulus(1'b1, 1'b1, 32'h200, 32'hFE00_0EE3, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h204, 32'h0000_007F, 1'b1);
    #1;
    vectors++;
    if ({bus.id_branch, bus.id_imm, bus.id_rd, bus.id_wb_en, bus.id_illegal} !==
        {1'b1, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL beq_decode: got br=%b imm=%h rd=%0d wb=%b ill=%b, want 1 fffffffc 0 0 0",
               bus.id_branch, bus.id_imm, bus.id_rd, bus.id_wb_en, bus.id_illegal);
    end
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    vectors++;
    if ({bus.id_validout, bus.id_illegal, bus.id_mem_load, bus.id_mem_store, bus.id_branch,
         bus.id_jal, bus.id_jalr, bus.id_wb_en} !== 8'b1100_0000) begin
      miscompares++;
      $display("[TB] FAIL illegal_decode: got %b want 11000000",
               {bus.id_validout, bus.id_illegal, bus.id_mem_load, bus.id_mem_store,
                bus.id_branch, bus.id_jal, bus.id_jalr, bus.id_wb_en});
    end
    tick();
  endtask

  task automatic test_backpressure();
    applyStimulus(1'b1, 1'b1, 32'h40, 32'h00A0_0513, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h44, 32'h13, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({bus.id_validout, bus.id_allowin, bus.id_pc, bus.id_inst, bus.id_rd, bus.id_imm} !==
          {1'b1, 1'b0, 32'h40, 32'h00A0_0513, 5'd10, 32'd10}) begin
        miscompares++;
        $display("[TB] FAIL backpressure_%0d: got v=%b a=%b pc=%h inst=%h rd=%0d imm=%h",
                 i, bus.id_validout, bus.id_allowin, bus.id_pc, bus.id_inst, bus.id_rd, bus.id_imm);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    vectors++;
    if ({bus.id_validout, bus.id_allowin, bus.id_pc, bus.id_inst} !== {1'b0, 1'b1, 32'h0, 32'h13}) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_hold: got v=%b a=%b pc=%h inst=%h, want 0 1 0 00000013",
               bus.id_validout, bus.id_allowin, bus.id_pc, bus.id_inst);
    end
  endtask

  task automatic test_no_done();
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0050_0093, 1'b1);
    tick();
    #1;
    vectors++;
    if ({bus.id_validout, bus.id_inst} !== {1'b0, 32'h13}) begin
      miscompares++;
      $display("[TB] FAIL no_ram_done: got v=%b inst=%h, want 0 00000013", bus.id_validout, bus.id_inst);
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111,
                              7'b1110011};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    w[11:7]  = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.if_validout   = ($urandom_range(0, 3) != 0);
      bus.ram_done      = ($urandom_range(0, 3) != 0);
      bus.if_ram_pc     = $urandom;
      bus.ram_rdata     = rand_inst();
      bus.ie_allowin    = ($urandom_range(0, 3) != 0);
      bus.ie_result_jmp = ($urandom_range(0, 15) == 0);
      bus.ie_valid      = ($urandom_range(0, 1) != 0);
      bus.ie_mem_load   = ($urandom_range(0, 1) != 0);
      bus.ie_rd         = 5'($urandom_range(0, 3));
      rst               = ($urandom_range(0, 63) == 0);
      #1;
      checkOutput(i);
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic checkOutput(input int idx);
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("[TB] FAIL random_%0d: got %h want %h", idx, dut_vec(), exp_vec());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mv          = 1'b0;
    mpc         = 32'h0;
    minst       = 32'h13;
    rst         = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    test_reset();
    test_addi();
    test_back_to_back();
    test_load_use();
    test_flush();
    test_decode_edges();
    test_backpressure();
    test_no_done();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_pipe_id.md
# core_pipe_id

Pipe ID (Instruction Decode), the second pipeline stage. It sits directly downstream of the fetch stage and upstream of IE. It captures each fetched 32-bit RV32I instruction word and its PC into a single-entry stage register, decodes it into register indices, immediate and control flags, and hands it to IE under a valid/allowin handshake. It also stalls on load-use hazards against the instruction in IE and flushes when IE resolves a jump.

## Interface
Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_validout  in  1  fetch stage presents a request.
- if_ram_pc  in  32  PC of the word being fetched.
- ram_done  in  1  RAM read data valid this cycle.
- ram_rdata  in  32  fetched instruction word.
- id_allowin  out  1  ID can accept a word this cycle (combinational).
- ie_allowin  in  1  IE can accept ID's output this cycle.
- ie_result_jmp  in  1  IE redirects the PC this cycle (flush).
- ie_valid  in  1  IE holds a valid instruction.
- ie_mem_load  in  1  the IE instruction is a load.
- ie_rd  in  5  destination register of the IE instruction.
- id_validout  out  1  decoded instruction offered to IE.
- id_pc  out  32  PC of the held instruction.
- id_inst  out  32  raw held instruction.
- id_rs1, id_rs2, id_rd  out  5 each  register indices; forced to 0 when the format does not use the field.
- id_imm  out  32  sign-extended immediate for the format.
- id_alu_op  out  4  {funct7[5] (R-type and shift-immediate only, else 0), funct3}.
- id_mem_load, id_mem_store, id_branch, id_jal, id_jalr, id_wb_en, id_illegal  out  1 each  decode flags.

## Operation
- State: valid bit `v`, 32-bit `pc_q`, 32-bit `inst_q`. All decode outputs are combinational from `inst_q`/`pc_q`.
- Hazard `stall` = v & ie_valid & ie_mem_load & (ie_rd != 0) & ((rs1 used & id_rs1 == ie_rd) | (rs2 used & id_rs2 == ie_rd)).
- id_validout = v & ~stall.
- id_allowin = ~v | (ie_allowin & ~stall).
- Accept = if_validout & ram_done & id_allowin & ~ie_result_jmp. On accept: `pc_q` ← if_ram_pc, `inst_q` ← ram_rdata, `v` ← 1.
- Handoff = id_validout & ie_allowin. On handoff without accept: `v` ← 0.
- Flush: ie_result_jmp forces `v` ← 0 and drops any word arriving in the same cycle. Flush has priority over accept, handoff and stall.
- Opcode decode (inst[6:0]):
  - 0110011 R: rs1, rs2, rd, wb.
  - 0010011 I-alu: rs1, rd, wb, I-imm.
  - 0000011 load: rs1, rd, wb, mem_load, I-imm.
  - 0100011 store: rs1, rs2, mem_store, S-imm.
  - 1100011 branch: rs1, rs2, branch, B-imm.
  - 1101111 JAL: rd, wb, jal, J-imm.
  - 1100111 JALR: rs1, rd, wb, jalr, I-imm.
  - 0110111 LUI and 0010111 AUIPC: rd, wb, U-imm.
  - 0001111 FENCE and 1110011 SYSTEM: no-op, legal.
  - Any other opcode: id_illegal = 1, all other flags 0.
- wb_en is forced to 0 when rd == 0.
- Immediates are sign-extended from inst[31]. U-imm = {inst[31:12], 12'b0}. B-imm and J-imm have bit 0 = 0.

## Timing
- Reset values: v = 0, pc_q = 0, inst_q = 0x00000013 (NOP). Therefore id_validout = 0, id_allowin = 1, id_illegal = 0, all flags 0.
- Latency: a word accepted at edge N is offered (id_validout = 1) in cycle N+1, unless stalled or flushed.
- Throughput: one instruction per cycle while ie_allowin = 1 and there is no stall (accept and handoff in the same cycle).
- Stall: holds the instruction with id_validout = 0. It releases the cycle after IE no longer holds the matching load.
- Backpressure: ie_allowin = 0 with v = 1 keeps all outputs stable and id_allowin = 0.
- Reset during operation: the next edge returns to the reset values and discards the held word.
- A word with if_validout = 1 but ram_done = 0 is not captured.

## Test plan
- Reset, then feed 0x00500093 (addi x1,x0,5) at pc 0x0 → next cycle: id_validout = 1, rd = 1, rs1 = 0, imm = 5, wb_en = 1, alu_op = 0.
- Back-to-back feed of 0x00000013 at pc 0, 4 and 8 with ie_allowin = 1 → id_pc steps 0, 4, 8 on consecutive cycles with no bubble.
- Hold a load-use pair: ie_valid = 1, ie_mem_load = 1, ie_rd = 1, with ID holding 0x00108133 (add x2,x1,x1) → id_validout = 0 and id_allowin = 0. Drop ie_valid → id_validout = 1 in the same cycle.
- ie_result_jmp = 1 while ID holds a word and a new word arrives with ram_done → next cycle id_validout = 0 and neither word is ever offered.
- Feed 0xFE000EE3 (beq, B-imm = -4) → branch = 1, imm = 0xFFFFFFFC, rd = 0, wb_en = 0. Then feed 0x0000007F → id_illegal = 1.
- Hold ie_allowin = 0 for 3 cycles with v = 1 → outputs stable and id_allowin = 0. Assert rst mid-hold → next cycle id_validout = 0 and id_allowin = 1.
